// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch unit.
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    STALL = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

  // Number of byte-offset bits below a word address.
  function automatic int unsigned oit_bits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO holding {pc, instr} entries; flush overrides push and pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PW = $clog2(DEPTH),
  localparam int unsigned CW = PW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push_en;
  logic             pop_en;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem[rd_ptr_q];

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign pop_en  = pop & ~empty;
  assign push_en = push & (~full | pop_en);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_en)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(push_en) - CW'(pop_en);
    end
  end

  always_ff @(posedge clk) begin
    if (push_en && !flush && !rst) mem[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/fetch_unit.sv
// Wishbone classic read master streaming sequential instruction words into a prefetch FIFO.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned SEL_WIDTH     = 4,
  parameter int unsigned DEPTH         = 4,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  output logic                     cyc_o,
  output logic                     stb_o,
  output logic                     we_o,
  output logic [SEL_WIDTH-1:0]     sel_o,
  output logic [ADDRESS_WIDTH-1:0] adr_o,
  input  logic [DATA_WIDTH-1:0]    dat_i,
  input  logic                     ack_i,
  input  logic                     err_i,
  input  logic                     rty_i,
  output logic                     instr_valid_o,
  output logic [DATA_WIDTH-1:0]    instr_o,
  output logic [ADDRESS_WIDTH-1:0] instr_pc_o,
  input  logic                     instr_ready_i,
  input  logic                     redirect_i,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc_i,
  output logic                     fault_o,
  output logic [ADDRESS_WIDTH-1:0] fault_adr_o
);

  localparam int unsigned ADDR_LSB = oit_bits(SEL_WIDTH);
  localparam int unsigned CW       = $clog2(DEPTH) + 1;
  localparam int unsigned EW       = ADDRESS_WIDTH + DATA_WIDTH;
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_MASK = ~((ADDRESS_WIDTH'(1) << ADDR_LSB) - 1'b1);

  fetch_state_t             state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] adr_q, adr_d;
  logic                     stb_q, stb_d;
  logic                     fault_q, fault_d;
  logic [ADDRESS_WIDTH-1:0] fault_adr_q, fault_adr_d;

  logic                     xfer_ack, xfer_err, xfer_rty;
  logic                     fifo_push, fifo_pop, fifo_flush;
  logic                     fifo_full, fifo_empty;
  logic [CW-1:0]            fifo_count;
  logic [CW-1:0]            count_next;
  logic                     room_next;
  logic [EW-1:0]            fifo_rdata;

  // Responses count only while strobing; err dominates rty, rty dominates ack.
  assign xfer_err = stb_q & err_i;
  assign xfer_rty = stb_q & rty_i & ~err_i;
  assign xfer_ack = stb_q & ack_i & ~err_i & ~rty_i;

  assign fifo_flush = redirect_i;
  assign fifo_pop   = instr_ready_i & ~fifo_empty & ~redirect_i;
  assign fifo_push  = xfer_ack & ~redirect_i & (~fifo_full | fifo_pop);

  always_comb begin
    count_next = '0;
    if (!redirect_i) begin
      count_next = fifo_count + CW'(fifo_push) - CW'(fifo_pop);
    end
  end

  assign room_next = (count_next < CW'(DEPTH));

  always_comb begin
    state_d     = state_q;
    adr_d       = adr_q;
    stb_d       = 1'b0;
    fault_d     = fault_q;
    fault_adr_d = fault_adr_q;

    if (redirect_i) begin
      // Bus idles one cycle so the flushed stream restarts cleanly.
      state_d = FETCH;
      adr_d   = redirect_pc_i & ADDR_MASK;
      fault_d = 1'b0;
    end else begin
      unique case (state_q)
        FETCH: begin
          if (xfer_err) begin
            state_d     = FAULT;
            fault_d     = 1'b1;
            fault_adr_d = adr_q;
          end else if (xfer_rty) begin
            state_d = STALL;
          end else begin
            if (xfer_ack) adr_d = adr_q + ADDRESS_WIDTH'(SEL_WIDTH);
            if (room_next) stb_d = 1'b1;
            else           state_d = STALL;
          end
        end
        STALL: begin
          if (room_next) begin
            state_d = FETCH;
            stb_d   = 1'b1;
          end
        end
        FAULT: begin
          state_d = FAULT;
        end
        default: begin
          state_d = FETCH;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= FETCH;
      adr_q       <= RESET_PC & ADDR_MASK;
      stb_q       <= 1'b0;
      fault_q     <= 1'b0;
      fault_adr_q <= '0;
    end else begin
      state_q     <= state_d;
      adr_q       <= adr_d;
      stb_q       <= stb_d;
      fault_q     <= fault_d;
      fault_adr_q <= fault_adr_d;
    end
  end

  fetch_fifo #(
    .WIDTH(EW),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk_i),
    .rst  (rst_i),
    .push (fifo_push),
    .pop  (fifo_pop),
    .flush(fifo_flush),
    .wdata({adr_q, dat_i}),
    .rdata(fifo_rdata),
    .count(fifo_count),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign cyc_o         = stb_q;
  assign stb_o         = stb_q;
  assign we_o          = 1'b0;
  assign sel_o         = '1;
  assign adr_o         = adr_q;
  assign instr_valid_o = ~fifo_empty;
  assign instr_pc_o    = fifo_rdata[EW-1:DATA_WIDTH];
  assign instr_o       = fifo_rdata[DATA_WIDTH-1:0];
  assign fault_o       = fault_q;
  assign fault_adr_o   = fault_adr_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: word-stream reference model plus directed literal checks.
module tb_fetch_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        cyc_o, stb_o, we_o;
  logic [3:0]  sel_o;
  logic [31:0] adr_o;
  logic [31:0] dat_i = '0;
  logic        ack_i = 1'b0, err_i = 1'b0, rty_i = 1'b0;
  logic        instr_valid_o;
  logic [31:0] instr_o, instr_pc_o;
  logic        instr_ready_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        fault_o;
  logic [31:0] fault_adr_o;

  always #5 clk = ~clk;

  fetch_unit #(
    .DATA_WIDTH   (32),
    .ADDRESS_WIDTH(32),
    .SEL_WIDTH    (4),
    .DEPTH        (DEPTH),
    .RESET_PC     (32'h0)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .cyc_o        (cyc_o),
    .stb_o        (stb_o),
    .we_o         (we_o),
    .sel_o        (sel_o),
    .adr_o        (adr_o),
    .dat_i        (dat_i),
    .ack_i        (ack_i),
    .err_i        (err_i),
    .rty_i        (rty_i),
    .instr_valid_o(instr_valid_o),
    .instr_o      (instr_o),
    .instr_pc_o   (instr_pc_o),
    .instr_ready_i(instr_ready_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .fault_o      (fault_o),
    .fault_adr_o  (fault_adr_o)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    int          cyc;
  } ent_t;

  // Reference model: buffered words, next fetch address, bus strobe, fault flag.
  ent_t        q[$];
  ent_t        plog[$];
  logic [31:0] m_pc;
  bit          m_stb, m_fault, m_ok;
  logic [31:0] m_fadr;

  int n_tests = 0, n_fail = 0, cyc = 0;

  int          ready_pct = 100, ack_pct = 100, rty_pct = 0, err_pct = 0;
  bit          noise = 0, rst_req = 0, redir_req = 0, err_arm = 0, rty_arm = 0;
  logic [31:0] redir_pc = '0, err_at = '0, rty_at = '0;

  function automatic logic [31:0] rom(input logic [31:0] pc);
    return pc >> 2;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic chk_log(input string name, input int idx, input logic [31:0] pc);
    if (idx < 0 || idx >= plog.size()) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: no delivered entry, expected pc %h", name, pc);
    end else begin
      chk({name, "_pc"}, plog[idx].pc, pc);
      chk({name, "_instr"}, plog[idx].instr, rom(pc));
    end
  endtask

  function automatic int first_after(input int r);
    foreach (plog[i]) if (plog[i].cyc > r) return i;
    return -1;
  endfunction

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    bit rty_acc;
    int r;
    ent_t e;
    @(negedge clk);
    cyc++;
    if (m_ok) begin
      chk("stb", stb_o, m_stb);
      chk("cyc", cyc_o, m_stb);
      chk("we", we_o, 0);
      chk("sel", sel_o, 4'hF);
      chk("adr", adr_o, m_pc);
      chk("valid", instr_valid_o, q.size() > 0);
      if (q.size() > 0) begin
        chk("head_pc", instr_pc_o, q[0].pc);
        chk("head_instr", instr_o, q[0].instr);
      end
      chk("fault", fault_o, m_fault);
      chk("fault_adr", fault_adr_o, m_fadr);
    end

    rst_i         = rst_req;
    redirect_i    = redir_req;
    redirect_pc_i = redir_pc;
    instr_ready_i = ($urandom_range(0, 99) < ready_pct);
    ack_i = 1'b0;
    err_i = 1'b0;
    rty_i = 1'b0;
    dat_i = $urandom;
    if (stb_o === 1'b1) begin
      dat_i = rom(adr_o);
      if (err_arm && adr_o == err_at) begin
        err_i = 1'b1;
        ack_i = 1'b1;
        err_arm = 0;
      end else if (rty_arm && adr_o == rty_at) begin
        rty_i = 1'b1;
        rty_arm = 0;
      end else begin
        r = $urandom_range(0, 99);
        if (r < err_pct) err_i = 1'b1;
        else if (r < err_pct + rty_pct) rty_i = 1'b1;
        else if (r < err_pct + rty_pct + ack_pct) ack_i = 1'b1;
      end
    end else if (noise) begin
      ack_i = ($urandom_range(0, 2) == 0);
      err_i = ($urandom_range(0, 3) == 0);
      rty_i = ($urandom_range(0, 3) == 0);
    end

    rty_acc = 0;
    if (rst_i) begin
      q.delete();
      m_pc = '0; m_stb = 0; m_fault = 0; m_fadr = '0; m_ok = 1;
    end else if (m_ok) begin
      if (redirect_i) begin
        q.delete();
        m_pc = redir_pc & ~32'h3;
        m_fault = 0;
        m_stb = 0;
      end else begin
        if (instr_ready_i && q.size() > 0) begin
          e = q.pop_front();
          e.cyc = cyc;
          plog.push_back(e);
        end
        if (m_stb) begin
          if (err_i) begin
            m_fault = 1;
            m_fadr = m_pc;
          end else if (rty_i) begin
            rty_acc = 1;
          end else if (ack_i) begin
            q.push_back('{pc: m_pc, instr: rom(m_pc), cyc: 0});
            m_pc = m_pc + 32'd4;
          end
        end
        m_stb = !m_fault && !rty_acc && (q.size() < DEPTH);
      end
    end
    redir_req = 0;
    rst_req = 0;
  endtask

  task automatic redirect_to(input logic [31:0] pc, output int rc);
    redir_pc = pc;
    redir_req = 1;
    step();
    rc = cyc;
  endtask

  initial begin
    int r, idx;
    m_ok = 0;

    repeat (3) begin rst_req = 1; step(); end
    settle();
    chk("rst_adr", adr_o, 32'h0);
    chk("rst_stb", stb_o, 0);
    chk("rst_valid", instr_valid_o, 0);
    chk("rst_fault", fault_o, 0);

    repeat (12) step();
    chk_log("boot0", 0, 32'h0);
    chk_log("boot1", 1, 32'h4);
    chk_log("boot2", 2, 32'h8);

    // Decode stalls: FIFO must hold exactly DEPTH words and stop strobing.
    ready_pct = 0;
    repeat (20) step();
    settle();
    chk("stall_stb", stb_o, 0);
    chk("stall_valid", instr_valid_o, 1);
    ready_pct = 100;
    repeat (10) step();

    redirect_to(32'h103, r);
    repeat (6) step();
    idx = first_after(r);
    chk_log("redir", idx, 32'h100);
    if (idx >= 0) chk("redir_latency", plog[idx].cyc, r + 3);

    rty_at = 32'h8;
    rty_arm = 1;
    redirect_to(32'h0, r);
    repeat (12) step();
    idx = first_after(r);
    chk_log("rty0", idx, 32'h0);
    chk_log("rty2", (idx < 0) ? -1 : idx + 2, 32'h8);
    chk_log("rty3", (idx < 0) ? -1 : idx + 3, 32'hC);

    ready_pct = 0;
    redirect_to(32'h30, r);
    repeat (8) step();
    err_at = 32'h40;
    err_arm = 1;
    ready_pct = 100;
    repeat (12) step();
    settle();
    chk("err_fault", fault_o, 1);
    chk("err_fault_adr", fault_adr_o, 32'h40);
    chk("err_stb", stb_o, 0);
    chk("err_drained", instr_valid_o, 0);
    chk_log("err_last", plog.size() - 1, 32'h3C);

    redirect_to(32'hFFFF_FFF8, r);
    repeat (8) step();
    idx = first_after(r);
    chk_log("wrap0", idx, 32'hFFFF_FFF8);
    chk_log("wrap1", (idx < 0) ? -1 : idx + 1, 32'hFFFF_FFFC);
    chk_log("wrap2", (idx < 0) ? -1 : idx + 2, 32'h0);

    rst_req = 1;
    step();
    settle();
    chk("midrst_adr", adr_o, 32'h0);
    chk("midrst_stb", stb_o, 0);
    chk("midrst_valid", instr_valid_o, 0);
    repeat (3) step();

    noise = 1;
    ack_pct = 70;
    rty_pct = 8;
    err_pct = 2;
    ready_pct = 60;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 4) begin
        redir_req = 1;
        redir_pc = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 1023))
                                               : (32'hFFFF_FFC0 | 32'($urandom_range(0, 63)));
      end
      if ($urandom_range(0, 999) < 3) rst_req = 1;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
